// File: rtl/register_file_pkg.sv
// Shared CPU constants: datapath width, register indexing and the XZR slot.
// The ALU and the control decoder import the same values.
package register_file_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 2 ** ADDR_WIDTH;
  localparam int XZR_INDEX  = 31;

  localparam int WRITE_COUNT_WIDTH = 16;

endpackage : register_file_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port. It handles the XZR index, the same-cycle
// write bypass and the selection of the stored register.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int REG_COUNT  = register_file_pkg::REG_COUNT,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic                                   input_reset,
  input  logic [ADDR_WIDTH-1:0]                  input_read_reg,
  input  logic                                   input_reg_write,
  input  logic [ADDR_WIDTH-1:0]                  input_write_reg,
  input  logic [DATA_WIDTH-1:0]                  input_write_data,
  input  logic [REG_COUNT-2:0][DATA_WIDTH-1:0]   input_regs,
  output logic [DATA_WIDTH-1:0]                  output_read_data
);

  localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(XZR_INDEX);

  // Reset and XZR both force zero, and reset also blocks the bypass path.
  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational; leaving
    // output_read_data unassigned on some branch would infer a latch.
    output_read_data = '0;
    if (!input_reset && input_read_reg != XZR) begin
      if (input_reg_write && input_write_reg == input_read_reg) begin
        output_read_data = input_write_data;
      end else begin
        for (int i = 0; i < REG_COUNT - 1; i++) begin
          if (input_read_reg == ADDR_WIDTH'(i)) output_read_data = input_regs[i];
        end
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// Register file with 31 stored registers plus XZR, two bypassing read
// ports and a 16-bit count of committed writes.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int REG_COUNT  = register_file_pkg::REG_COUNT,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic                  input_clk,
  input  logic                  input_reset,
  input  logic [ADDR_WIDTH-1:0] input_read_reg_1,
  input  logic [ADDR_WIDTH-1:0] input_read_reg_2,
  input  logic [ADDR_WIDTH-1:0] input_write_reg,
  input  logic [DATA_WIDTH-1:0] input_write_data,
  input  logic                  input_reg_write,
  output logic [DATA_WIDTH-1:0] output_read_data_1,
  output logic [DATA_WIDTH-1:0] output_read_data_2,
  output logic [15:0]           output_write_count
);

  localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(XZR_INDEX);

  logic [REG_COUNT-2:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [WRITE_COUNT_WIDTH-1:0]         write_count_q, write_count_d;
  logic                                 write_commit;

  assign write_commit = input_reg_write && (input_write_reg != XZR);

  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (write_commit) begin
      for (int i = 0; i < REG_COUNT - 1; i++) begin
        if (input_write_reg == ADDR_WIDTH'(i)) regs_d[i] = input_write_data;
      end
      write_count_d = write_count_q + 1'b1;
    end
  end

  // The async reset has priority, so a write on an edge that meets reset is dropped.
  always_ff @(posedge input_clk or posedge input_reset) begin
    if (input_reset) begin
      // NOTE: the storage is cleared on reset on purpose. Software expects every
      // register to read zero after reset, so this array cannot map to an
      // unreset RAM macro.
      regs_q        <= '0;
      write_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value
      // from before the edge.
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  assign output_write_count = write_count_q;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_1 (
    .input_reset      (input_reset),
    .input_read_reg   (input_read_reg_1),
    .input_reg_write  (input_reg_write),
    .input_write_reg  (input_write_reg),
    .input_write_data (input_write_data),
    .input_regs       (regs_q),
    .output_read_data (output_read_data_1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_2 (
    .input_reset      (input_reset),
    .input_read_reg   (input_read_reg_2),
    .input_reg_write  (input_reg_write),
    .input_write_reg  (input_write_reg),
    .input_write_data (input_write_data),
    .input_regs       (regs_q),
    .output_read_data (output_read_data_2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file. It covers reset, XZR, bypass, the write
// enable, a mid-cycle reset and the wrap of the write counter.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] read_data_1, read_data_2;
  logic [15:0] write_count;

  int n_checks = 0;
  int n_pass   = 0;

  register_file dut (
    .input_clk          (clk),
    .input_reset        (rst),
    .input_read_reg_1   (read_reg_1),
    .input_read_reg_2   (read_reg_2),
    .input_write_reg    (write_reg),
    .input_write_data   (write_data),
    .input_reg_write    (reg_write),
    .output_read_data_1 (read_data_1),
    .output_read_data_2 (read_data_2),
    .output_write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Returns 1 ns after the rising edge, away from the clock.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 64'h55;
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd5;
    #2;
    check("reset_bypass_suppressed_1", read_data_1, 64'h0);
    check("reset_bypass_suppressed_2", read_data_2, 64'h0);
    tick();
    reg_write = 1'b0;
    #12 rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      read_reg_1 = 5'(i);
      read_reg_2 = 5'(31 - i);
      #1;
      check($sformatf("reset_read1_x%0d", i), read_data_1, 64'h0);
      check($sformatf("reset_read2_x%0d", 31 - i), read_data_2, 64'h0);
    end
    check("reset_count", {48'h0, write_count}, 64'h0);

    // The first write after reset is X5.
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 64'h0000_0000_DEAD_BEEF;
    tick();
    reg_write  = 1'b0;
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd5;
    #1;
    check("x5_read1", read_data_1, 64'h0000_0000_DEAD_BEEF);
    check("x5_read2", read_data_2, 64'h0000_0000_DEAD_BEEF);
    check("x5_count", {48'h0, write_count}, 64'd1);

    // A write to XZR is ignored, and XZR reads zero even during that write.
    reg_write  = 1'b1;
    write_reg  = 5'd31;
    write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    read_reg_1 = 5'd31;
    read_reg_2 = 5'd31;
    #1;
    check("xzr_same_cycle_1", read_data_1, 64'h0);
    check("xzr_same_cycle_2", read_data_2, 64'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("xzr_next_cycle", read_data_1, 64'h0);
    check("xzr_count", {48'h0, write_count}, 64'd1);

    // Write X7 = 1, then bypass X7 = 0x2A on both ports.
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 64'h1;
    tick();
    write_data = 64'h2A;
    read_reg_1 = 5'd7;
    read_reg_2 = 5'd7;
    #1;
    check("bypass_before_edge_2", read_data_2, 64'h2A);
    check("bypass_before_edge_1", read_data_1, 64'h2A);
    tick();
    reg_write = 1'b0;
    #1;
    check("bypass_after_edge_2", read_data_2, 64'h2A);
    check("bypass_count", {48'h0, write_count}, 64'd3);

    // A write with the enable low must not change X3.
    write_reg  = 5'd3;
    write_data = 64'h10;
    read_reg_1 = 5'd3;
    read_reg_2 = 5'd5;
    tick();
    #1;
    check("disabled_write_x3", read_data_1, 64'h0);
    check("disabled_write_x5", read_data_2, 64'h0000_0000_DEAD_BEEF);
    check("disabled_write_count", {48'h0, write_count}, 64'd3);

    // Write X3, then assert reset mid-cycle: the registers clear without a clock edge.
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    #1;
    check("x3_written", read_data_1, 64'h10);
    check("x3_count", {48'h0, write_count}, 64'd4);
    #1 rst = 1'b1;
    #1;
    check("async_reset_x3", read_data_1, 64'h0);
    check("async_reset_x5", read_data_2, 64'h0);
    check("async_reset_count", {48'h0, write_count}, 64'd0);
    rst = 1'b0;

    // 65536 writes to X1 wrap the write counter back to zero.
    reg_write  = 1'b1;
    write_reg  = 5'd1;
    read_reg_1 = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      write_data = 64'(i);
      tick();
    end
    check("count_before_wrap", {48'h0, write_count}, 64'hFFFF);
    write_data = 64'hFFFF;
    tick();
    reg_write = 1'b0;
    #1;
    check("count_wrapped", {48'h0, write_count}, 64'h0);
    check("x1_last_data", read_data_1, 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_register_file
